mesi_snoop_ctrl: RTL

//  Parametrised snooping MESI coherency controller for NUM_CORES private L1 data caches.

---
 rtl/mesi_snoop_ctrl_pkg.sv | 40 ++++
 rtl/mesi_snoop_ctrl_rr_arbiter.sv | 48 ++++
 rtl/mesi_snoop_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mesi_snoop_ctrl_pkg.sv
// Shared encodings for the MESI snoop controller: line states, bus ops, FSM states.
package mesi_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    typedef enum logic [1:0] {
        OP_BUSRD   = 2'b00,
        OP_BUSRDX  = 2'b01,
        OP_BUSUPGR = 2'b10,
        OP_WB      = 2'b11
    } bus_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_MEM_WAIT,
        ST_RESP
    } state_e;

    function automatic int unsigned core_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Fill state handed back to the requester once the transaction completes.
    function automatic mesi_e fill_state(input bus_op_e op, input logic peer_hit);
        case (op)
            OP_BUSRD: return peer_hit ? MESI_S : MESI_E;
            OP_WB:    return MESI_I;
            default:  return MESI_M;
        endcase
    endfunction

endpackage

// File: rtl/mesi_snoop_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the slot after the last winner.
module rr_arbiter
    import mesi_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = core_idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] gnt_idx_o
);

    logic [W-1:0] ptr_q, ptr_d;
    logic         found;
    int unsigned  idx;
    logic [W-1:0] bi;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        ptr_d     = ptr_q;
        found     = 1'b0;
        idx       = 0;
        bi        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            bi  = W'(idx);
            if (!found && req_i[bi]) begin
                found     = 1'b1;
                gnt_o[bi] = 1'b1;
                gnt_idx_o = bi;
                ptr_d     = W'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (adv_i && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mesi_snoop_ctrl.sv
// Snooping MESI coherency controller: arbitrates L1 requests onto one snoop bus,
// gathers snoop acks, sources fills from a dirty peer or memory, returns the fill state.
module mesi_snoop_ctrl
    import mesi_pkg::*;
#(
    parameter int unsigned NUM_CORES     = 4,
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned SNOOP_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [2*NUM_CORES-1:0]        req_op,
    input  logic [ADDR_W*NUM_CORES-1:0]   req_addr,
    input  logic [DATA_W*NUM_CORES-1:0]   req_wdata,
    output logic [NUM_CORES-1:0]          req_ready,
    output logic                          snp_valid,
    output logic [1:0]                    snp_op,
    output logic [ADDR_W-1:0]             snp_addr,
    output logic [$clog2(NUM_CORES)-1:0]  snp_src,
    input  logic [NUM_CORES-1:0]          snp_ack,
    input  logic [NUM_CORES-1:0]          snp_hit,
    input  logic [NUM_CORES-1:0]          snp_dirty,
    input  logic [DATA_W*NUM_CORES-1:0]   snp_data,
    output logic                          mem_req_valid,
    output logic                          mem_req_we,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [DATA_W-1:0]             mem_req_wdata,
    input  logic                          mem_req_ready,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [NUM_CORES-1:0]          rsp_valid,
    output logic [1:0]                    rsp_state,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          busy,
    output logic                          err
);

    localparam int unsigned CIW = core_idx_w(NUM_CORES);
    localparam int unsigned TW  = $clog2(SNOOP_TIMEOUT + 1);

    state_e                 state_q;
    bus_op_e                op_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [CIW-1:0]         src_q;
    logic [NUM_CORES-1:0]   mask_q;
    logic [TW-1:0]          tmo_q;
    logic                   hit_q, dfound_q;
    logic [CIW-1:0]         didx_q;
    logic [DATA_W-1:0]      fill_q;
    logic [NUM_CORES-1:0]   req_ready_q, rsp_valid_q;
    logic                   snp_valid_q, mem_valid_q, mem_we_q, busy_q, err_q;
    logic [DATA_W-1:0]      mem_wdata_q, rsp_data_q;
    mesi_e                  rsp_state_q;

    logic [NUM_CORES-1:0]   gnt;
    logic [CIW-1:0]         gnt_idx;
    bus_op_e                sel_op;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;

    rr_arbiter #(.N(NUM_CORES), .W(CIW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .adv_i     (state_q == ST_IDLE),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        sel_op    = OP_BUSRD;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (gnt[i]) begin
                sel_op    = bus_op_e'(req_op[i*2 +: 2]);
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    logic [NUM_CORES-1:0] src_oh, peer_ack, mask_n, cur_dirty, cur_hit;
    logic                 all_acked, cdf, proto_err, take_new, timeout, snp_exit;
    logic                 dfound_n, hit_n, eff_dirty, eff_hit, to_resp;
    logic [CIW-1:0]       cdidx, didx_n;
    logic [DATA_W-1:0]    cdata, flush_n, rsp_fill;

    always_comb begin
        src_oh         = '0;
        src_oh[src_q]  = 1'b1;
        peer_ack       = snp_ack & ~src_oh;
        mask_n         = mask_q | snp_ack;
        all_acked      = &mask_n;
        cur_dirty      = peer_ack & snp_dirty;
        cur_hit        = peer_ack & snp_hit;
        cdf            = 1'b0;
        cdidx          = '0;
        cdata          = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!cdf && cur_dirty[i]) begin
                cdf   = 1'b1;
                cdidx = CIW'(i);
                cdata = snp_data[i*DATA_W +: DATA_W];
            end
        end
        // A second dirty owner may arrive in a later cycle; keep the lower index.
        proto_err = ($countones(cur_dirty) > 1) || (cdf && dfound_q) || (|(cur_dirty & ~snp_hit));
        take_new  = cdf && (!dfound_q || (cdidx < didx_q));
        dfound_n  = dfound_q | cdf;
        didx_n    = take_new ? cdidx : didx_q;
        flush_n   = take_new ? cdata : fill_q;
        hit_n     = hit_q | (|cur_hit);
        timeout   = !all_acked && (tmo_q == TW'(SNOOP_TIMEOUT - 1));
        snp_exit  = all_acked || timeout;
        eff_dirty = dfound_n && !timeout;
        eff_hit   = hit_n && !timeout;
        rsp_fill  = (state_q == ST_MEM_RD || state_q == ST_MEM_WAIT) ? mem_rdata : fill_q;
        to_resp   = ((state_q == ST_SNOOP) && snp_exit && !eff_dirty && (op_q == OP_BUSUPGR))
                 || ((state_q == ST_MEM_WR) && mem_req_ready)
                 || ((state_q == ST_MEM_RD) && mem_req_ready && mem_rvalid)
                 || ((state_q == ST_MEM_WAIT) && mem_rvalid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_BUSRD;
            addr_q      <= '0;
            src_q       <= '0;
            mask_q      <= '0;
            tmo_q       <= '0;
            hit_q       <= 1'b0;
            dfound_q    <= 1'b0;
            didx_q      <= '0;
            fill_q      <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            snp_valid_q <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rsp_state_q <= MESI_I;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        req_ready_q <= gnt;
                        op_q        <= sel_op;
                        addr_q      <= sel_addr;
                        src_q       <= gnt_idx;
                        mask_q      <= gnt;
                        tmo_q       <= '0;
                        hit_q       <= 1'b0;
                        dfound_q    <= 1'b0;
                        didx_q      <= '0;
                        fill_q      <= '0;
                        busy_q      <= 1'b1;
                        if (sel_op == OP_WB) begin
                            state_q     <= ST_MEM_WR;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= sel_wdata;
                        end else begin
                            state_q     <= ST_SNOOP;
                            snp_valid_q <= 1'b1;
                        end
                    end
                end
                ST_SNOOP: begin
                    mask_q   <= mask_n;
                    tmo_q    <= tmo_q + TW'(1);
                    hit_q    <= hit_n;
                    dfound_q <= dfound_n;
                    didx_q   <= didx_n;
                    fill_q   <= flush_n;
                    if (proto_err || timeout) err_q <= 1'b1;
                    if (snp_exit) begin
                        snp_valid_q <= 1'b0;
                        hit_q       <= eff_hit;
                        dfound_q    <= eff_dirty;
                        if (eff_dirty) begin
                            state_q     <= ST_MEM_WR;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= flush_n;
                        end else if (op_q != OP_BUSUPGR) begin
                            state_q     <= ST_MEM_RD;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= 1'b0;
                        end
                    end
                end
                ST_MEM_WR: begin
                    if (mem_req_ready) begin
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_req_ready) begin
                        mem_valid_q <= 1'b0;
                        if (!mem_rvalid) state_q <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    rsp_state_q <= MESI_I;
                    rsp_data_q  <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
            // Every path into RESP funnels through here so the response fields are built once.
            if (to_resp) begin
                state_q     <= ST_RESP;
                rsp_valid_q <= src_oh;
                rsp_state_q <= fill_state(op_q, hit_q);
                rsp_data_q  <= (op_q == OP_BUSRD || op_q == OP_BUSRDX) ? rsp_fill : '0;
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign snp_valid     = snp_valid_q;
    assign snp_op        = op_q;
    assign snp_addr      = addr_q;
    assign snp_src       = src_q;
    assign mem_req_valid = mem_valid_q;
    assign mem_req_we    = mem_we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = mem_wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_state     = rsp_state_q;
    assign rsp_data      = rsp_data_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule
